// File: rtl/fp_alu_pkg.sv
// Shared FP ALU definitions: unit select codes and the default result width.
// Used by the legacy ALU result mux and by fp_result_arbiter.
package fp_alu_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int NUM_SEL_CODES = 4;

  typedef enum logic [1:0] {
    SEL_ADD = 2'd0,
    SEL_SUB = 2'd1,
    SEL_MUL = 2'd2,
    SEL_DIV = 2'd3
  } fp_sel_e;

  // A select is legal only when it names an instantiated execution unit.
  function automatic logic sel_is_legal(input int unsigned sel, input int unsigned num_units);
    return sel < num_units;
  endfunction

endpackage

// File: rtl/fp_sel_fifo.sv
// In-order queue of issued unit selects. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter register.
module fp_sel_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  diff;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Modular pointer difference is the occupancy, including the full case.
  assign diff  = wr_ptr - rd_ptr;
  assign count = CW'(diff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fp_result_arbiter.sv
// Registered, in-order FP result arbiter: queues issued selects, waits for the
// head unit's result, acks it and presents it on a valid/ready output port.
module fp_result_arbiter
  import fp_alu_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 4,
  parameter int SEL_W     = $clog2(NUM_UNITS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [SEL_W-1:0]           issue_sel,
  output logic                       issue_ready,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS-1:0]       unit_valid,
  output logic [NUM_UNITS-1:0]       unit_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       err_sel
);

  logic             q_full;
  logic             q_empty;
  logic [SEL_W-1:0] head;
  logic             legal;
  logic             push;
  logic             capture;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;

  fp_sel_fifo #(
    .W     (SEL_W),
    .DEPTH (DEPTH)
  ) u_sel_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (issue_sel),
    .pop       (capture),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (pending)
  );

  // No bypass: a pop in the same cycle does not free a slot for this issue.
  assign issue_ready = !q_full;
  assign legal       = sel_is_legal(32'(issue_sel), NUM_UNITS);
  assign push        = issue_valid && issue_ready && legal;

  always_comb begin
    head_valid = 1'b0;
    head_data  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (head == SEL_W'(i)) begin
        head_valid = unit_valid[i];
        head_data  = unit_result[i*WIDTH +: WIDTH];
      end
    end
  end

  assign capture = !q_empty && head_valid && (!out_valid || out_ready);

  // Only the head unit is ever acked; valids from other units wait their turn.
  always_comb begin
    unit_ack = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_ack[i] = capture && (head == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= head_data;
      out_sel   <= head;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else if (issue_valid && issue_ready && !legal) begin
      err_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_result_arbiter.sv
// Bench for fp_result_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_fp_result_arbiter;

  localparam int WIDTH = 32;
  localparam int NU    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic             issue_valid;
  logic [1:0]       issue_sel;
  logic             issue_ready;
  logic [NU*32-1:0] unit_result;
  logic [NU-1:0]    unit_valid;
  logic [NU-1:0]    unit_ack;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [1:0]       out_sel;
  logic [2:0]       pending;
  logic             err_sel;

  // Three-unit instance used for the illegal-select case.
  logic        issue_valid3;
  logic [1:0]  issue_sel3;
  logic        issue_ready3;
  logic [95:0] unit_result3;
  logic [2:0]  unit_valid3;
  logic [2:0]  unit_ack3;
  logic        out_valid3;
  logic        out_ready3;
  logic [31:0] out_data3;
  logic [1:0]  out_sel3;
  logic [2:0]  pending3;
  logic        err_sel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_result_arbiter #(
    .WIDTH(WIDTH), .NUM_UNITS(NU), .DEPTH(DEPTH), .SEL_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_ready(issue_ready),
    .unit_result(unit_result), .unit_valid(unit_valid), .unit_ack(unit_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .pending(pending), .err_sel(err_sel)
  );

  fp_result_arbiter #(
    .WIDTH(WIDTH), .NUM_UNITS(3), .DEPTH(DEPTH), .SEL_W(2)
  ) dut3 (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid3), .issue_sel(issue_sel3), .issue_ready(issue_ready3),
    .unit_result(unit_result3), .unit_valid(unit_valid3), .unit_ack(unit_ack3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_sel(out_sel3), .pending(pending3), .err_sel(err_sel3)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [1:0] sel, input logic rdy);
    issue_valid = iv;
    issue_sel   = sel;
    out_ready   = rdy;
  endtask

  task automatic setUnit(input int i, input logic [31:0] d);
    unit_valid[i]            = 1'b1;
    unit_result[i*32 +: 32]  = d;
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock; units drop their valid once they have been acked.
  task automatic step();
    logic [NU-1:0] ack_snap;
    #1;
    ack_snap = unit_ack;
    @(posedge clk);
    #1;
    unit_valid = unit_valid & ~ack_snap;
  endtask

  // Reference model: a queue of outstanding selects and one output slot.
  int unsigned mq[$];
  logic        m_ov;
  logic [31:0] m_data;
  logic [1:0]  m_sel;
  logic        m_err;

  always @(negedge clk) begin : compare
    bit            full;
    bit            cap;
    int            head;
    logic [NU-1:0] eack;
    if (rst) begin
      mq.delete();
      m_ov   = 1'b0;
      m_data = '0;
      m_sel  = '0;
      m_err  = 1'b0;
      checkOutput("rst_issue_ready", 64'(issue_ready), 64'(1));
      checkOutput("rst_unit_ack",    64'(unit_ack),    64'(0));
      checkOutput("rst_out_valid",   64'(out_valid),   64'(0));
      checkOutput("rst_pending",     64'(pending),     64'(0));
      checkOutput("rst_err_sel",     64'(err_sel),     64'(0));
    end else begin
      full = (mq.size() == DEPTH);
      cap  = 1'b0;
      head = 0;
      eack = '0;
      if (mq.size() > 0) begin
        head = int'(mq[0]);
        cap  = unit_valid[head] && (!m_ov || out_ready);
      end
      if (cap) eack[head] = 1'b1;
      checkOutput("issue_ready", 64'(issue_ready), 64'(!full));
      checkOutput("unit_ack",    64'(unit_ack),    64'(eack));
      checkOutput("out_valid",   64'(out_valid),   64'(m_ov));
      if (m_ov) begin
        checkOutput("out_data", 64'(out_data), 64'(m_data));
        checkOutput("out_sel",  64'(out_sel),  64'(m_sel));
      end
      checkOutput("pending", 64'(pending), 64'(mq.size()));
      checkOutput("err_sel", 64'(err_sel), 64'(m_err));
      if (cap) begin
        void'(mq.pop_front());
        m_ov   = 1'b1;
        m_data = unit_result[head*32 +: 32];
        m_sel  = 2'(head);
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (issue_valid && !full) begin
        if (int'(issue_sel) < NU) mq.push_back(int'(issue_sel));
        else m_err = 1'b1;
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 2'd0, 1'b1);
    unit_valid   = '0;
    unit_result  = '0;
    issue_valid3 = 1'b0;
    issue_sel3   = 2'd0;
    unit_result3 = '0;
    unit_valid3  = '0;
    out_ready3   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_data", 64'(out_data), 64'(0));
    checkOutput("reset_out_sel",  64'(out_sel),  64'(0));
    rst = 1'b0;

    // Basic order: mul result goes straight through.
    applyStimulus(1'b1, 2'd2, 1'b1); step();
    applyStimulus(1'b0, 2'd0, 1'b1); setUnit(2, 32'h40490FDB); settle();
    checkOutput("basic_ack",     64'(unit_ack), 64'(4'b0100));
    checkOutput("basic_pending", 64'(pending),  64'(1));
    step(); settle();
    checkOutput("basic_out_valid", 64'(out_valid), 64'(1));
    checkOutput("basic_out_data",  64'(out_data),  64'(32'h40490FDB));
    checkOutput("basic_out_sel",   64'(out_sel),   64'(2));
    checkOutput("basic_pending0",  64'(pending),   64'(0));
    checkOutput("basic_ack_off",   64'(unit_ack),  64'(0));
    step();
    checkOutput("basic_drain", 64'(out_valid), 64'(0));

    // Out-of-order units: div issued first must leave first.
    applyStimulus(1'b1, 2'd3, 1'b1); step();
    applyStimulus(1'b1, 2'd0, 1'b1); step();
    applyStimulus(1'b0, 2'd0, 1'b1); setUnit(0, 32'h3F800000);
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput("ooo_no_ack", 64'(unit_ack), 64'(0));
      step();
    end
    setUnit(3, 32'h40000000); settle();
    checkOutput("ooo_ack3", 64'(unit_ack), 64'(4'b1000));
    step(); settle();
    checkOutput("ooo_first_data", 64'(out_data), 64'(32'h40000000));
    checkOutput("ooo_first_sel",  64'(out_sel),  64'(3));
    checkOutput("ooo_ack0",       64'(unit_ack), 64'(4'b0001));
    step();
    checkOutput("ooo_second_data", 64'(out_data), 64'(32'h3F800000));
    checkOutput("ooo_second_sel",  64'(out_sel),  64'(0));
    step();
    checkOutput("ooo_drain", 64'(out_valid), 64'(0));

    // Backpressure: first result held stable, second unit waits.
    applyStimulus(1'b1, 2'd1, 1'b0); step();
    applyStimulus(1'b1, 2'd2, 1'b0); step();
    applyStimulus(1'b0, 2'd0, 1'b0);
    setUnit(1, 32'hC0A00000); setUnit(2, 32'h41200000); settle();
    checkOutput("bp_ack1", 64'(unit_ack), 64'(4'b0010));
    step();
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput("bp_no_ack",  64'(unit_ack),  64'(0));
      checkOutput("bp_valid",   64'(out_valid), 64'(1));
      checkOutput("bp_hold",    64'(out_data),  64'(32'hC0A00000));
      checkOutput("bp_pending", 64'(pending),   64'(1));
      step();
    end
    applyStimulus(1'b0, 2'd0, 1'b1); settle();
    checkOutput("bp_ack2", 64'(unit_ack), 64'(4'b0100));
    step();
    checkOutput("bp_b2b_valid", 64'(out_valid), 64'(1));
    checkOutput("bp_b2b_data",  64'(out_data),  64'(32'h41200000));
    step();
    checkOutput("bp_drain", 64'(out_valid), 64'(0));

    // Full queue, no bypass on a same-cycle pop.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 2'(s), 1'b1); step();
    end
    applyStimulus(1'b0, 2'd0, 1'b1); settle();
    checkOutput("full_pending", 64'(pending),     64'(4));
    checkOutput("full_ready",   64'(issue_ready), 64'(0));
    applyStimulus(1'b1, 2'd0, 1'b1); step();
    applyStimulus(1'b1, 2'd1, 1'b1); setUnit(0, 32'h3F000000); settle();
    checkOutput("full_reject",   64'(pending),     64'(4));
    checkOutput("full_pop_ack",  64'(unit_ack),    64'(4'b0001));
    checkOutput("full_no_bypass",64'(issue_ready), 64'(0));
    step();
    applyStimulus(1'b0, 2'd0, 1'b1); settle();
    checkOutput("full_ready_again", 64'(issue_ready), 64'(1));
    checkOutput("full_pending3",    64'(pending),     64'(3));
    setUnit(1, 32'h11111111); setUnit(2, 32'h22222222); setUnit(3, 32'h33333333);
    repeat (5) step();
    checkOutput("full_drained", 64'(pending),   64'(0));
    checkOutput("full_idle",    64'(out_valid), 64'(0));

    // Illegal select on the three-unit instance.
    checkOutput("ill_err_init", 64'(err_sel3), 64'(0));
    issue_valid3 = 1'b1; issue_sel3 = 2'd3; settle();
    checkOutput("ill_ready", 64'(issue_ready3), 64'(1));
    step();
    issue_valid3 = 1'b0;
    checkOutput("ill_err",     64'(err_sel3),   64'(1));
    checkOutput("ill_pending", 64'(pending3),   64'(0));
    checkOutput("ill_no_out",  64'(out_valid3), 64'(0));
    issue_valid3 = 1'b1; issue_sel3 = 2'd1; step();
    issue_valid3 = 1'b0; step();
    checkOutput("ill_legal_push", 64'(pending3), 64'(1));
    checkOutput("ill_sticky",     64'(err_sel3), 64'(1));

    // Reset mid-operation: three queued plus a held output.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 2'(s), 1'b0); step();
    end
    applyStimulus(1'b0, 2'd0, 1'b0); setUnit(0, 32'h12345678); step(); settle();
    checkOutput("mid_out_valid", 64'(out_valid), 64'(1));
    checkOutput("mid_pending",   64'(pending),   64'(3));
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid",   64'(out_valid),   64'(0));
    checkOutput("mid_rst_data",    64'(out_data),    64'(0));
    checkOutput("mid_rst_pending", 64'(pending),     64'(0));
    checkOutput("mid_rst_ready",   64'(issue_ready), 64'(1));
    checkOutput("mid_rst_ack",     64'(unit_ack),    64'(0));
    checkOutput("mid_rst_err3",    64'(err_sel3),    64'(0));
    unit_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 2'd1, 1'b1); step();
    applyStimulus(1'b0, 2'd0, 1'b1); setUnit(1, 32'hBF800000); step();
    checkOutput("resume_data", 64'(out_data), 64'(32'hBF800000));
    checkOutput("resume_sel",  64'(out_sel),  64'(1));
    step();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_sel   = 2'($urandom_range(0, 3));
      out_ready   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NU; i++) begin
        if (!unit_valid[i] && $urandom_range(0, 2) == 0) setUnit(i, $urandom);
      end
      step();
    end
    applyStimulus(1'b0, 2'd0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NU; i++) begin
        if (!unit_valid[i]) setUnit(i, $urandom);
      end
      step();
    end
    checkOutput("final_pending", 64'(pending), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
